// File: rtl/adc_cfg_sequencer.sv
// Walks an 8-entry register table and issues one SPI write per valid entry, with a
// per-write acknowledge/transfer timeout and a fixed idle gap between writes.
module adc_cfg_sequencer #(
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned ACK_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tbl_we_i,
  input  logic [2:0]  tbl_idx_i,
  input  logic        tbl_valid_i,
  input  logic [3:0]  tbl_addr_i,
  input  logic [15:0] tbl_data_i,
  input  logic        seq_start_i,
  input  logic        spi_cs_n_i,
  output logic        spi_start_o,
  output logic [3:0]  spi_addr_o,
  output logic [15:0] spi_data_o,
  output logic        seq_busy_o,
  output logic        seq_done_o,
  output logic        seq_err_o,
  output logic [3:0]  xfer_cnt_o
);

  // The ISSUE clock and the cs_n-low sample that leaves WAIT_LOW both count toward their
  // budgets, so the dwell limit in the waiting state is two short of the nominal figure.
  localparam logic [15:0] AckLast = (ACK_CYC >= 2) ? 16'(ACK_CYC - 2) : 16'd0;
  localparam logic [15:0] ToLast  = 16'(TIMEOUT_CYC - 2);
  localparam logic [15:0] GapLast = 16'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWaitLow,
    StWaitHigh,
    StGap,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] tmr_q, tmr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic [7:0]  tbl_valid_q;
  logic [3:0]  tbl_addr_q [8];
  logic [15:0] tbl_data_q [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid_q <= '0;
      for (int i = 0; i < 8; i++) begin
        tbl_addr_q[i] <= '0;
        tbl_data_q[i] <= '0;
      end
    end else if (tbl_we_i && !seq_busy_o) begin
      tbl_valid_q[tbl_idx_i] <= tbl_valid_i;
      tbl_addr_q[tbl_idx_i]  <= tbl_addr_i;
      tbl_data_q[tbl_idx_i]  <= tbl_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (seq_start_i) begin
          state_d = StFetch;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StFetch: begin
        if (idx_q[3]) begin
          state_d = StFinish;
        end else if (tbl_valid_q[idx_q[2:0]]) begin
          addr_d  = tbl_addr_q[idx_q[2:0]];
          data_d  = tbl_data_q[idx_q[2:0]];
          state_d = StIssue;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StIssue: state_d = StWaitLow;
      StWaitLow: begin
        if (!spi_cs_n_i) begin
          state_d = StWaitHigh;
        end else if (tmr_q == AckLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitHigh: begin
        if (spi_cs_n_i) begin
          cnt_d   = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;
          state_d = StGap;
        end else if (tmr_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StGap: begin
        if (tmr_q == GapLast) begin
          idx_d   = idx_q + 4'd1;
          state_d = StFetch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tmr_d = tmr_q + 16'd1;
    if (state_d != state_q || state_q == StIdle) begin
      tmr_d = '0;
    end
  end

  assign spi_start_o = (state_q == StIssue);
  assign seq_done_o  = (state_q == StFinish);
  assign seq_busy_o  = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWaitLow) ||
                       (state_q == StWaitHigh) || (state_q == StGap);
  assign spi_addr_o  = addr_q;
  assign spi_data_o  = data_q;
  assign seq_err_o   = err_q;
  assign xfer_cnt_o  = cnt_q;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Scoreboard bench: a timing model of the sequence predicts every spi_start, seq_done and
// seq_err event; a monitor pops and compares them as the DUT produces them.
module tb_adc_cfg_sequencer;
  localparam int unsigned GapCyc = 8;
  localparam int unsigned ToCyc  = 1023;
  localparam int unsigned AckCyc = 4;
  localparam int unsigned Never  = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_we = 1'b0;
  logic [2:0]  tbl_idx = '0;
  logic        tbl_valid = 1'b0;
  logic [3:0]  tbl_addr = '0;
  logic [15:0] tbl_data = '0;
  logic        seq_start = 1'b0;
  logic        cs_n = 1'b1;
  logic        spi_start, seq_busy, seq_done, seq_err;
  logic [3:0]  spi_addr, xfer_cnt;
  logic [15:0] spi_data;

  adc_cfg_sequencer #(.GAP_CYC(GapCyc), .TIMEOUT_CYC(ToCyc), .ACK_CYC(AckCyc)) dut (
    .clk(clk), .rst_n(rst_n), .tbl_we_i(tbl_we), .tbl_idx_i(tbl_idx), .tbl_valid_i(tbl_valid),
    .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data), .seq_start_i(seq_start), .spi_cs_n_i(cs_n),
    .spi_start_o(spi_start), .spi_addr_o(spi_addr), .spi_data_o(spi_data),
    .seq_busy_o(seq_busy), .seq_done_o(seq_done), .seq_err_o(seq_err), .xfer_cnt_o(xfer_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;  // 0 write, 1 done, 2 error
    int unsigned cyc;
    int unsigned addr;
    int unsigned data;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];
  exp_t model_q[$];
  int checks = 0;
  int errors = 0;

  bit          sh_v [8];
  logic [3:0]  sh_a [8];
  logic [15:0] sh_d [8];
  int unsigned pl_lat [8];
  int unsigned pl_dur [8];
  int unsigned plan_n = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_m(input int kind, input int unsigned c, input int unsigned a,
                                 input int unsigned d, input int unsigned n);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d; e.cnt = n;
    model_q.push_back(e);
  endfunction

  // Predicted events for a seq_start seen in cycle k: one clock per fetched entry, the ISSUE
  // clock, the SPI response, then the gap; cs_n must fall before t+AckCyc and may stay low
  // for fewer than ToCyc clocks.
  task automatic model_seq(input int unsigned k);
    int unsigned c, t, n;
    c = k + 1;
    n = 0;
    model_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (!sh_v[i]) begin
        c++;
        continue;
      end
      t = c + 1;
      push_m(0, t, sh_a[i], sh_d[i], 0);
      if (pl_lat[n] >= AckCyc) begin
        push_m(2, t + AckCyc, 0, 0, n);
        return;
      end
      if (pl_dur[n] >= ToCyc) begin
        push_m(2, t + pl_lat[n] + ToCyc, 0, 0, n);
        return;
      end
      c = t + pl_lat[n] + pl_dur[n] + 1 + GapCyc;
      n++;
    end
    push_m(1, c + 1, 0, 0, n);
  endtask

  // SPI write master stand-in driven from the shared per-write plan.
  initial begin
    int unsigned l, d;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        l = pl_lat[plan_n];
        d = pl_dur[plan_n];
        plan_n++;
        if (l != Never) begin
          repeat (l) @(posedge clk);
          #1 cs_n = 1'b0;
          repeat (d) @(posedge clk);
          #1 cs_n = 1'b1;
        end
      end
    end
  end

  task automatic on_event(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind %0d at cycle %0d: got an event, required none", kind,
               cyc);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.cyc);
    if (kind == 0) begin
      chk("spi_addr", spi_addr, e.addr);
      chk("spi_data", spi_data, e.data);
      chk("busy_at_write", seq_busy, 1);
    end else if (kind == 1) begin
      chk("done_xfer_cnt", xfer_cnt, e.cnt);
      chk("done_busy", seq_busy, 0);
      chk("done_err", seq_err, 0);
    end else begin
      chk("err_xfer_cnt", xfer_cnt, e.cnt);
      chk("err_busy", seq_busy, 0);
      chk("err_done", seq_done, 0);
    end
  endtask

  initial begin
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_start) on_event(0);
      if (seq_done) on_event(1);
      if (seq_err && !err_prev) on_event(2);
      err_prev = seq_err;
    end
  end

  task automatic tbl_write(input int idx, input bit v, input logic [3:0] a, input logic [15:0] d);
    tbl_we = 1'b1; tbl_idx = 3'(idx); tbl_valid = v; tbl_addr = a; tbl_data = d;
    tick();
    tbl_we = 1'b0;
    sh_v[idx] = v; sh_a[idx] = a; sh_d[idx] = d;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 8; i++) tbl_write(i, 1'b0, 4'h0, 16'h0);
  endtask

  // Optional same-cycle table write; only predicted events before cycle lim are queued.
  task automatic start_seq(input bit wr, input int idx, input bit v, input logic [3:0] a,
                           input logic [15:0] d, input int unsigned lim);
    if (wr) begin
      tbl_we = 1'b1; tbl_idx = 3'(idx); tbl_valid = v; tbl_addr = a; tbl_data = d;
      sh_v[idx] = v; sh_a[idx] = a; sh_d[idx] = d;
    end
    plan_n = 0;
    model_seq(cyc);
    foreach (model_q[i]) if (model_q[i].cyc < lim) sb.push_back(model_q[i]);
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    tbl_we = 1'b0;
    chk("start_busy", seq_busy, 1);
    chk("start_err_clear", seq_err, 0);
    chk("start_cnt_clear", xfer_cnt, 0);
  endtask

  task automatic drain();
    int unsigned dl;
    dl = cyc + 3000;
    if (sb.size() != 0) dl = sb[sb.size() - 1].cyc + 20;
    while (sb.size() != 0 && cyc < dl) tick();
    repeat (12) tick();
    chk("scoreboard_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_cs_high();
    for (int i = 0; i < 3000 && !cs_n; i++) tick();
    chk("cs_n_release", cs_n, 1);
  endtask

  task automatic set_plan(input int unsigned l, input int unsigned d);
    for (int i = 0; i < 8; i++) begin
      pl_lat[i] = l;
      pl_dur[i] = d;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_addr", spi_addr, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_err", seq_err, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t2;
    bit cowr;
    for (int i = 0; i < 8; i++) begin
      sh_v[i] = 1'b0; sh_a[i] = '0; sh_d[i] = '0;
    end
    set_plan(1, 5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    tick();
    rst_n = 1'b1;
    tick();

    // Empty table: done ten clocks after start, nothing issued.
    start_seq(1'b0, 0, 1'b0, 4'h0, 16'h0, '1);
    drain();

    // Two valid entries with a long cs_n low window.
    tbl_write(0, 1'b1, 4'h1, 16'h3FFF);
    tbl_write(2, 1'b1, 4'hF, 16'h007F);
    set_plan(1, 330);
    start_seq(1'b0, 0, 1'b0, 4'h0, 16'h0, '1);
    drain();

    // No acknowledge: error after the ack budget, cleared by the next start.
    clear_table();
    tbl_write(0, 1'b1, 4'h3, 16'hA5A5);
    set_plan(Never, 0);
    start_seq(1'b0, 0, 1'b0, 4'h0, 16'h0, '1);
    drain();
    set_plan(1, 5);
    start_seq(1'b0, 0, 1'b0, 4'h0, 16'h0, '1);
    drain();

    // cs_n stuck low past the transfer timeout.
    set_plan(1, 2000);
    start_seq(1'b0, 0, 1'b0, 4'h0, 16'h0, '1);
    drain();
    wait_cs_high();

    // Table write and start while busy are ignored.
    tbl_write(0, 1'b1, 4'h5, 16'h1234);
    set_plan(1, 20);
    start_seq(1'b0, 0, 1'b0, 4'h0, 16'h0, '1);
    repeat (3) tick();
    tbl_we = 1'b1; tbl_idx = 3'd0; tbl_valid = 1'b1; tbl_addr = 4'hA; tbl_data = 16'hBEEF;
    seq_start = 1'b1;
    tick();
    tbl_we = 1'b0;
    seq_start = 1'b0;
    drain();
    start_seq(1'b0, 0, 1'b0, 4'h0, 16'h0, '1);
    drain();

    // Randomised tables and SPI responses, sometimes writing an entry with the start.
    for (int it = 0; it < 20; it++) begin
      for (int n = 0; n < 8; n++) begin
        pl_lat[n] = ($urandom_range(7, 0) == 0) ? Never : $urandom_range(AckCyc - 1, 1);
        pl_dur[n] = $urandom_range(40, 1);
      end
      cowr = 1'($urandom_range(1, 0));
      for (int i = 0; i < (cowr ? 7 : 8); i++)
        tbl_write(i, 1'($urandom_range(1, 0)), 4'($urandom), 16'($urandom));
      start_seq(cowr, 7, 1'($urandom_range(1, 0)), 4'($urandom), 16'($urandom), '1);
      drain();
      wait_cs_high();
    end

    // Reset during the second write's cs_n-low window.
    clear_table();
    tbl_write(0, 1'b1, 4'h2, 16'h0F0F);
    tbl_write(1, 1'b1, 4'h9, 16'hC3C3);
    set_plan(1, 300);
    plan_n = 0;
    model_seq(cyc);
    t2 = model_q[1].cyc;
    start_seq(1'b0, 0, 1'b0, 4'h0, 16'h0, t2 + 1);
    while (cyc < t2 + 50) tick();
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs();
    for (int i = 0; i < 8; i++) begin
      sh_v[i] = 1'b0; sh_a[i] = '0; sh_d[i] = '0;
    end
    wait_cs_high();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("scoreboard_empty_after_reset", sb.size(), 0);
    start_seq(1'b0, 0, 1'b0, 4'h0, 16'h0, '1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
